// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the two-requester FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/fifo_arb_stat_counter.sv
// Saturating grant counter; holds at all-ones once it gets there.
module fifo_arb_stat_counter
  import fifo_arb_pkg::*;
#(
  parameter int W = STAT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Burst-limited two-requester arbiter feeding one FIFO write port.
// Define FIFO_ARB_STATS_EN to add the stat0/stat1 per-requester grant counters.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             full,
  output logic             gnt0,
  output logic             gnt1,
  output logic             write,
  output logic [WIDTH-1:0] inputBus,
  output arb_state_t       dbg_state
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat0,
  output logic [STAT_W-1:0] stat1
`endif
);

  localparam logic [3:0] CNT_LAST = 4'(BURST - 1);

  arb_state_t state, state_n;
  logic [3:0] count, count_n;
  logic       last, last_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_n;
      count <= count_n;
      last  <= last_n;
    end
  end

  // A full FIFO stalls the owner in place; only a dropped request or an
  // exhausted burst hands ownership over.
  always_comb begin
    state_n = state;
    count_n = count;
    last_n  = last;
    case (state)
      IDLE: begin
        count_n = '0;
        if (req0 && req1) state_n = last ? OWN0 : OWN1;
        else if (req0)    state_n = OWN0;
        else if (req1)    state_n = OWN1;
      end
      OWN0: begin
        if (!req0) begin
          state_n = req1 ? OWN1 : IDLE;
          count_n = '0;
        end else if (!full) begin
          if (count == CNT_LAST) begin
            count_n = '0;
            if (req1) state_n = OWN1;
          end else begin
            count_n = count + 4'd1;
          end
        end
      end
      OWN1: begin
        if (!req1) begin
          state_n = req0 ? OWN0 : IDLE;
          count_n = '0;
        end else if (!full) begin
          if (count == CNT_LAST) begin
            count_n = '0;
            if (req0) state_n = OWN0;
          end else begin
            count_n = count + 4'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
    if (state_n == OWN0)      last_n = 1'b0;
    else if (state_n == OWN1) last_n = 1'b1;
  end

  always_comb begin
    gnt0     = (state == OWN0) && req0 && !full;
    gnt1     = (state == OWN1) && req1 && !full;
    write    = gnt0 || gnt1;
    inputBus = (state == OWN1) ? data1 : data0;
  end

  assign dbg_state = state;

`ifdef FIFO_ARB_STATS_EN
  fifo_arb_stat_counter #(.W(STAT_W)) u_stat0 (
    .clk   (clk),
    .reset (reset),
    .en    (gnt0),
    .count (stat0)
  );

  fifo_arb_stat_counter #(.W(STAT_W)) u_stat1 (
    .clk   (clk),
    .reset (reset),
    .en    (gnt1),
    .count (stat1)
  );
`endif

endmodule
